// File: rtl/mux2_1_simple.sv
// 2:1 selector with a zero-latency combinational output, a registered copy of
// the selected data, a valid flag and a saturating count of select changes.
module mux2_1_simple #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     i0,
  input  logic [WIDTH-1:0]     i1,
  input  logic                 sel,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] sel_changes
);

  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     data_d;
  logic                 valid_q;
  logic                 sel_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 sel_edge;
  logic                 cnt_sat;

  // Combinational select; an X/Z select merges bitwise so equal bits pass through.
  always_comb begin
    out = sel ? i1 : i0;
  end

  // Next-state for the registered data and the saturating change counter.
  always_comb begin
    data_d   = sel ? i1 : i0;
    // Only count once a post-reset sample of sel exists in sel_q.
    sel_edge = valid_q && (sel != sel_q);
    cnt_sat  = (cnt_q == {CNT_WIDTH{1'b1}});
    cnt_d    = cnt_q;
    if (sel_edge && !cnt_sat) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= 1'b1;
      sel_q   <= sel;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_q       = data_q;
    out_valid   = valid_q;
    sel_changes = cnt_q;
  end

endmodule

// File: tb/tb_mux2_1_simple.sv
// Self-checking bench for mux2_1_simple: vector table for the combinational
// path, directed reset/saturation sequences and randomized clocked traffic.
module tb_mux2_1_simple;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  i0;
  logic [W-1:0]  i1;
  logic          sel;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic          out_valid;
  logic [CW-1:0] sel_changes;

  int checks = 0;
  int errors = 0;

  // Reference model state: behaviour derived from the selection rules.
  logic [W-1:0] exp_q;
  logic         exp_valid;
  int           exp_cnt;
  logic         have_sample;
  logic         last_sel;

  mux2_1_simple #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i0          (i0),
    .i1          (i1),
    .sel         (sel),
    .out         (out),
    .out_q       (out_q),
    .out_valid   (out_valid),
    .sel_changes (sel_changes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         sel;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] both[2];
    both[0] = a;
    both[1] = b;
    return both[s];
  endfunction

  task automatic model_reset();
    exp_q       = '0;
    exp_valid   = 1'b0;
    exp_cnt     = 0;
    have_sample = 1'b0;
    last_sel    = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"}, 32'(out_q), 32'(exp_q));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".sel_changes"}, 32'(sel_changes), 32'(exp_cnt));
  endtask

  // One rising edge: update the model with the inputs seen at the edge, then check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      exp_q = pick(sel, i0, i1);
      if (have_sample && (sel != last_sel) && (exp_cnt < CNT_MAX)) exp_cnt++;
      last_sel    = sel;
      have_sample = 1'b1;
      exp_valid   = 1'b1;
    end
    #1;
    check_regs(tag);
    check({tag, ".out"}, 32'(out), 32'(pick(sel, i0, i1)));
  endtask

  initial begin
    rst_n = 1'b0;
    i0    = '0;
    i1    = '0;
    sel   = 1'b0;
    model_reset();

    vecs[0] = '{i0: 4'h0, i1: 4'h0, sel: 1'b0, exp: 4'h0};
    vecs[1] = '{i0: 4'h0, i1: 4'h0, sel: 1'b1, exp: 4'h0};
    vecs[2] = '{i0: 4'hA, i1: 4'h5, sel: 1'b0, exp: 4'hA};
    vecs[3] = '{i0: 4'hA, i1: 4'h5, sel: 1'b1, exp: 4'h5};
    vecs[4] = '{i0: 4'hF, i1: 4'h0, sel: 1'b1, exp: 4'h0};
    vecs[5] = '{i0: 4'h0, i1: 4'hF, sel: 1'b0, exp: 4'h0};
    vecs[6] = '{i0: 4'h3, i1: 4'hC, sel: 1'b1, exp: 4'hC};
    vecs[7] = '{i0: 4'h9, i1: 4'h9, sel: 1'b0, exp: 4'h9};

    // Combinational path, held in reset so no clock dependence is possible.
    #2;
    for (int k = 0; k < 8; k++) begin
      i0  = vecs[k].i0;
      i1  = vecs[k].i1;
      sel = vecs[k].sel;
      #1;
      check($sformatf("vec%0d.out", k), 32'(out), 32'(vecs[k].exp));
    end

    // sel=1: out tracks i1, i0 changes are ignored.
    sel = 1'b1;
    i1  = 4'h0;
    for (int k = 0; k < 6; k++) begin
      i1 = ~i1;
      i0 = 4'(k);
      #5;
      check("follow_i1", 32'(out), 32'(i1));
    end

    // sel=0: out tracks i0, i1 changes are ignored.
    sel = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i0 = 4'(k * 3);
      i1 = ~i1;
      #1;
      check("follow_i0", 32'(out), 32'(i0));
    end

    // Reset state, then deassert mid-cycle: nothing changes until the next edge.
    @(posedge clk);
    #2;
    check_regs("in_reset");
    rst_n = 1'b1;
    i0    = 4'h1;
    sel   = 1'b0;
    #1;
    check_regs("post_release");
    tick("first_edge");
    check("first_edge.valid_lit", 32'(out_valid), 32'd1);
    check("first_edge.q_lit", 32'(out_q), 32'h1);
    check("first_edge.no_count", 32'(sel_changes), 32'd0);

    // Toggle sel every edge long enough to saturate the counter.
    for (int k = 0; k < 300; k++) begin
      sel = ~sel;
      i0  = 4'($urandom);
      i1  = 4'($urandom);
      tick("sat");
    end
    check("sat.final", 32'(sel_changes), 32'(CNT_MAX));

    // Asynchronous reset mid-count, away from any edge.
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst_sat");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sel = ~sel;
      tick("recount");
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    i0 = 4'h6;
    i1 = 4'hB;
    sel = 1'b1;
    #1;
    check_regs("async_rst_mid");
    check("async_rst_mid.out", 32'(out), 32'hB);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model, including occasional async resets.
    for (int k = 0; k < 400; k++) begin
      i0  = 4'($urandom);
      i1  = 4'($urandom);
      sel = 1'($urandom);
      #1;
      check("rand.out", 32'(out), 32'(pick(sel, i0, i1)));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("rand_rst");
        rst_n = 1'b1;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
